// File: rtl/regfile_wb_arbiter.sv
// Three-requester round-robin write-back arbiter in front of a register file.
// Produces one registered write per accepted request, with one-cycle latency.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 21,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req_valid,
    input  logic [3*ADDR_W-1:0]   req_reg,
    input  logic [3*DATA_W-1:0]   req_data,
    output logic [2:0]            req_ready,
    output logic                  RegWrite,
    output logic [ADDR_W-1:0]     write_reg,
    output logic [DATA_W-1:0]     write_data,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic [7:0]            grant_count
);

    // Handshake: requester i transfers in a cycle where req_valid[i] && req_ready[i];
    // it holds valid/reg/data stable until then, and req_ready never depends on
    // anything but the current requests, last_gnt and rst.

    logic [1:0]          last_gnt;
    logic [1:0]          cand0, cand1, cand2;
    logic [1:0]          gnt_idx;
    logic                gnt_any;
    logic                transfer;
    logic [ADDR_W-1:0]   sel_reg;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REGS-1:0] pending_next;

    // Search order starts one past the last winner and ends on the last winner.
    always_comb begin
        case (last_gnt)
            2'd0: begin
                cand0 = 2'd1;
                cand1 = 2'd2;
                cand2 = 2'd0;
            end
            2'd1: begin
                cand0 = 2'd2;
                cand1 = 2'd0;
                cand2 = 2'd1;
            end
            default: begin
                cand0 = 2'd0;
                cand1 = 2'd1;
                cand2 = 2'd2;
            end
        endcase
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        if (req_valid[cand0]) begin
            gnt_any = 1'b1;
            gnt_idx = cand0;
        end else if (req_valid[cand1]) begin
            gnt_any = 1'b1;
            gnt_idx = cand1;
        end else if (req_valid[cand2]) begin
            gnt_any = 1'b1;
            gnt_idx = cand2;
        end
    end

    always_comb begin
        req_ready = 3'b000;
        if (rst && gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign transfer = |req_ready;
    assign sel_reg  = req_reg[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign sel_data = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

    always_comb begin
        pending_next = '0;
        for (int i = 0; i < 3; i++) begin
            if (req_valid[i] && !req_ready[i]) begin
                pending_next[req_reg[i*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt     <= 2'd2;
            RegWrite     <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
            pending_mask <= '0;
            grant_count  <= 8'd0;
        end else begin
            RegWrite     <= transfer;
            pending_mask <= pending_next;
            if (transfer) begin
                last_gnt    <= gnt_idx;
                write_reg   <= sel_reg;
                write_data  <= sel_data;
                grant_count <= grant_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a table of per-cycle vectors plus
// hand-written reset, contention and counter-wrap sequences.
module tb_regfile_wb_arbiter;

    localparam int DATA_W   = 21;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    logic                  clk;
    logic                  rst;
    logic [2:0]            req_valid;
    logic [3*ADDR_W-1:0]   req_reg;
    logic [3*DATA_W-1:0]   req_data;
    logic [2:0]            req_ready;
    logic                  RegWrite;
    logic [ADDR_W-1:0]     write_reg;
    logic [DATA_W-1:0]     write_data;
    logic [NUM_REGS-1:0]   pending_mask;
    logic [7:0]            grant_count;

    int n_cmp;
    int n_fail;

    regfile_wb_arbiter #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_reg     (req_reg),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .RegWrite    (RegWrite),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .pending_mask(pending_mask),
        .grant_count (grant_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]          valid;
        logic [3*ADDR_W-1:0] regs;
        logic [3*DATA_W-1:0] data;
        logic [2:0]          ready;
        logic                rw;
        logic [ADDR_W-1:0]   wr;
        logic [DATA_W-1:0]   wd;
        logic [NUM_REGS-1:0] pm;
        logic [7:0]          gc;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] v,
                                input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2,
                                input logic [20:0] d0, input logic [20:0] d1, input logic [20:0] d2,
                                input logic [2:0] rdy, input logic rw, input logic [3:0] wr,
                                input logic [20:0] wd, input logic [15:0] pm, input logic [7:0] gc);
        vec_t t;
        t.valid = v;
        t.regs  = {r2, r1, r0};
        t.data  = {d2, d1, d0};
        t.ready = rdy;
        t.rw    = rw;
        t.wr    = wr;
        t.wd    = wd;
        t.pm    = pm;
        t.gc    = gc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: present one cycle of requests, check the combinational grant,
    // then check the registered outputs just after the clock edge.
    task automatic run_vec(input vec_t t, input string tag);
        @(negedge clk);
        req_valid = t.valid;
        req_reg   = t.regs;
        req_data  = t.data;
        #1;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(t.ready));
        @(posedge clk);
        #1;
        chk({tag, ".RegWrite"}, 32'(RegWrite), 32'(t.rw));
        chk({tag, ".write_reg"}, 32'(write_reg), 32'(t.wr));
        chk({tag, ".write_data"}, 32'(write_data), 32'(t.wd));
        chk({tag, ".pending_mask"}, 32'(pending_mask), 32'(t.pm));
        chk({tag, ".grant_count"}, 32'(grant_count), 32'(t.gc));
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 3'b000;
        #1;
        chk({tag, ".rst.RegWrite"}, 32'(RegWrite), 32'd0);
        chk({tag, ".rst.write_reg"}, 32'(write_reg), 32'd0);
        chk({tag, ".rst.write_data"}, 32'(write_data), 32'd0);
        chk({tag, ".rst.pending_mask"}, 32'(pending_mask), 32'd0);
        chk({tag, ".rst.grant_count"}, 32'(grant_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t vecs[12];

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b0;
        req_valid = 3'b000;
        req_reg   = '0;
        req_data  = '0;

        // Cycle-by-cycle sequence from reset (last_gnt=2, so ALU leads).
        vecs[0]  = mk(3'b000, 4'd0, 4'd0, 4'd0, 21'd0,   21'd0,   21'd0, 3'b000, 1'b0, 4'd0, 21'd0,   16'h0000, 8'd0);
        vecs[1]  = mk(3'b001, 4'd2, 4'd0, 4'd0, 21'd50,  21'd0,   21'd0, 3'b001, 1'b1, 4'd2, 21'd50,  16'h0000, 8'd1);
        vecs[2]  = mk(3'b000, 4'd0, 4'd0, 4'd0, 21'd0,   21'd0,   21'd0, 3'b000, 1'b0, 4'd2, 21'd50,  16'h0000, 8'd1);
        vecs[3]  = mk(3'b011, 4'd4, 4'd4, 4'd0, 21'd100, 21'd200, 21'd0, 3'b010, 1'b1, 4'd4, 21'd200, 16'h0010, 8'd2);
        vecs[4]  = mk(3'b001, 4'd4, 4'd0, 4'd0, 21'd100, 21'd0,   21'd0, 3'b001, 1'b1, 4'd4, 21'd100, 16'h0000, 8'd3);
        vecs[5]  = mk(3'b101, 4'd5, 4'd0, 4'd6, 21'd1,   21'd0,   21'd3, 3'b100, 1'b1, 4'd6, 21'd3,   16'h0020, 8'd4);
        vecs[6]  = mk(3'b101, 4'd5, 4'd0, 4'd7, 21'd1,   21'd0,   21'd4, 3'b001, 1'b1, 4'd5, 21'd1,   16'h0080, 8'd5);
        vecs[7]  = mk(3'b101, 4'd8, 4'd0, 4'd7, 21'd7,   21'd0,   21'd4, 3'b100, 1'b1, 4'd7, 21'd4,   16'h0100, 8'd6);
        vecs[8]  = mk(3'b101, 4'd8, 4'd0, 4'd9, 21'd7,   21'd0,   21'd9, 3'b001, 1'b1, 4'd8, 21'd7,   16'h0200, 8'd7);
        vecs[9]  = mk(3'b110, 4'd0, 4'd0, 4'd9, 21'd0,   21'h1FFFFF, 21'd9, 3'b010, 1'b1, 4'd0, 21'h1FFFFF, 16'h0200, 8'd8);
        vecs[10] = mk(3'b100, 4'd0, 4'd0, 4'd9, 21'd0,   21'd0,   21'd9, 3'b100, 1'b1, 4'd9, 21'd9,   16'h0000, 8'd9);
        vecs[11] = mk(3'b000, 4'd0, 4'd0, 4'd0, 21'd0,   21'd0,   21'd0, 3'b000, 1'b0, 4'd9, 21'd9,   16'h0000, 8'd9);

        #2;
        chk("init.req_ready", 32'(req_ready), 32'd0);
        chk("init.RegWrite", 32'(RegWrite), 32'd0);
        chk("init.grant_count", 32'(grant_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("tbl%0d", i));
        end

        // Three-way contention straight out of reset.
        apply_reset("rr3");
        run_vec(mk(3'b111, 4'd1, 4'd2, 4'd3, 21'd10, 21'd20, 21'd30, 3'b001, 1'b1, 4'd1, 21'd10, 16'h000C, 8'd1), "rr3.c0");
        run_vec(mk(3'b110, 4'd1, 4'd2, 4'd3, 21'd10, 21'd20, 21'd30, 3'b010, 1'b1, 4'd2, 21'd20, 16'h0008, 8'd2), "rr3.c1");
        run_vec(mk(3'b100, 4'd1, 4'd2, 4'd3, 21'd10, 21'd20, 21'd30, 3'b100, 1'b1, 4'd3, 21'd30, 16'h0000, 8'd3), "rr3.c2");
        run_vec(mk(3'b000, 4'd0, 4'd0, 4'd0, 21'd0, 21'd0, 21'd0, 3'b000, 1'b0, 4'd3, 21'd30, 16'h0000, 8'd3), "rr3.c3");

        // Reset asserted in the middle of a cycle that grants MEM.
        apply_reset("mid");
        run_vec(mk(3'b001, 4'd3, 4'd0, 4'd0, 21'd5, 21'd0, 21'd0, 3'b001, 1'b1, 4'd3, 21'd5, 16'h0000, 8'd1), "mid.pre");
        @(negedge clk);
        req_valid = 3'b010;
        req_reg   = {4'd0, 4'd11, 4'd0};
        req_data  = {21'd0, 21'd77, 21'd0};
        #1;
        chk("mid.grant_mem", 32'(req_ready), 32'b010);
        #1;
        rst = 1'b0;
        #1;
        chk("mid.async.req_ready", 32'(req_ready), 32'd0);
        chk("mid.async.RegWrite", 32'(RegWrite), 32'd0);
        chk("mid.async.write_reg", 32'(write_reg), 32'd0);
        chk("mid.async.write_data", 32'(write_data), 32'd0);
        chk("mid.async.grant_count", 32'(grant_count), 32'd0);
        @(posedge clk);
        #1;
        chk("mid.held.RegWrite", 32'(RegWrite), 32'd0);
        chk("mid.held.grant_count", 32'(grant_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid.release.req_ready", 32'(req_ready), 32'b010);
        @(posedge clk);
        #1;
        chk("mid.release.RegWrite", 32'(RegWrite), 32'd1);
        chk("mid.release.write_reg", 32'(write_reg), 32'd11);
        chk("mid.release.write_data", 32'(write_data), 32'd77);
        chk("mid.release.grant_count", 32'(grant_count), 32'd1);
        @(negedge clk);
        req_valid = 3'b000;
        @(posedge clk);
        #1;
        chk("mid.once.RegWrite", 32'(RegWrite), 32'd0);
        chk("mid.once.grant_count", 32'(grant_count), 32'd1);

        // 256 back-to-back single-requester writes wrap the counter to 0.
        apply_reset("wrap");
        for (int k = 0; k < 256; k++) begin
            run_vec(mk(3'b001, 4'(k), 4'd0, 4'd0, 21'(k + 1000), 21'd0, 21'd0,
                       3'b001, 1'b1, 4'(k), 21'(k + 1000), 16'h0000, 8'((k + 1) % 256)),
                    $sformatf("wrap%0d", k));
        end
        chk("wrap.final_count", 32'(grant_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
